alu_bit_serial_seq: RTL and testbench
=====================================

// Module: alu_bit_serial_seq
// PURPOSE
//   Bit-serial WIDTH-bit ALU sequencer. Accepts two operands and a mode, then
//   streams one bit pair per clock, LSB first, through a single ALU_1_bit slice.
//   The slice carry is registered between bits, and the slice F outputs are
//   collected into the result word. Sits directly upstream of ALU_1_bit: it
//   supplies A/B/Cin/M0/M1 and consumes F/Cout. It is the area-cheap
//   alternative to the ripple 4-bit ALU.
// PARAMETERS
//   WIDTH    4   operand/result width in bits (>=2)
//   CNT_W    2   bit-index counter width, = clog2(WIDTH)
// PORTS
//   clk      in   1      single clock, rising edge
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      request; sampled only in IDLE or DONE
//   a        in   WIDTH  operand A, captured on accepted start
//   b        in   WIDTH  operand B, captured on accepted start
//   cin      in   1      carry-in for bit 0, captured on accepted start
//   m0, m1   in   1      slice mode, captured and held stable for whole op
//   busy     out  1      high while bits are being processed
//   done     out  1      one-cycle pulse: result/cout/zero valid
//   result   out  WIDTH  collected slice F bits, held until next accepted start
//   cout     out  1      slice Cout of bit WIDTH-1
//   zero     out  1      result == 0, registered with result
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE. busy, done, result, cout and zero are 0.
//     The carry register and bit index are 0. An op in flight is aborted and
//     produces no done.
//   - FSM states IDLE, SHIFT, DONE, encoded 2'b00/01/10. 2'b11 -> IDLE.
//   - IDLE: when start=1, capture a, b, cin, m0, m1 into shadow registers;
//     idx<=0, carry<=cin, go to SHIFT.
//   - SHIFT (busy=1): drive the slice with A=a_sh[idx], B=b_sh[idx], Cin=carry,
//     and the held mode. On each edge: res_sh[idx]<=F, carry<=Cout, idx<=idx+1.
//     When idx==WIDTH-1, go to DONE and load result/cout/zero from the final
//     values. Processing takes exactly WIDTH cycles.
//   - DONE: done=1 for this single cycle, busy=0. Next state is SHIFT if start=1
//     (a new op is captured; back-to-back ops are allowed), else IDLE.
//   - Latency: done is high in cycle WIDTH+1 after the accepting start edge.
//     Throughput is one op per WIDTH+1 cycles.
//   - start in SHIFT is ignored. Operand/mode input changes after acceptance
//     have no effect.
//   - result, cout and zero change only on the SHIFT->DONE edge. They stay
//     stable through IDLE.
//   - In mode M1M0=00 (add): {cout,result} = a + b + cin, modulo 2^(WIDTH+1).
//     Other modes: result[i] = slice F for bit i with the chained carry.
//   - Slice output N is not consumed.
//   - idx wraps naturally only when WIDTH = 2^CNT_W. The terminal compare uses
//     WIDTH-1, never overflow.
// STRUCTURE
//   - Shared header alu_defs.vh holds the state encodings (S_IDLE/S_SHIFT/
//     S_DONE) and the mode constants (MODE_ADD=2'b00, etc.), also used by the
//     ripple ALU.
//   - One sub-module: ALU_1_bit, instantiated once as the combinational datapath.
//   - Local logic: FSM, idx counter, carry flop, shadow regs, result shift/
//     collect reg.
// TESTING
//   1. rst pulse mid-cycle (async) -> all outputs 0 immediately, state IDLE,
//      no done afterward.
//   2. add: a=4'h5 b=4'h3 cin=0 -> busy 4 cycles, done on 5th cycle;
//      result=4'h8 cout=0 zero=0.
//   3. add: a=4'hF b=4'h0 cin=1 -> result=4'h0 cout=1 zero=1.
//   4. start re-asserted with a=4'h1 during SHIFT -> ignored; original
//      result/done timing unchanged.
//   5. start held high at done -> second op (a=4'h7 b=4'h7 cin=1 -> result=4'hF
//      cout=0) completes with no idle gap.
//   6. rst asserted in cycle 2 of SHIFT -> no done. Next op a=4'h2 b=4'h2 ->
//      result=4'h4 with the correct fresh carry.

Source files
------------

// File: rtl/alu_bit_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: FSM state encoding,
// slice mode encoding and the single-bit carry helper.
package alu_bit_serial_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // {M1, M0} slice mode; ModeAdd is the one the ripple ALU also relies on.
  typedef enum logic [1:0] {
    ModeAdd = 2'b00,
    ModeSub = 2'b01,
    ModeAnd = 2'b10,
    ModeXor = 2'b11
  } mode_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_bit_serial_seq_alu_1_bit.sv
// One-bit ALU slice: add / subtract (A + ~B + Cin) with carry out, and
// bitwise AND / XOR which pass the incoming carry straight through.
module alu_bit_serial_seq_alu_1_bit
  import alu_bit_serial_seq_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  logic m0_i,
  input  logic m1_i,
  output logic f_o,
  output logic cout_o
);

  mode_e mode;
  assign mode = mode_e'({m1_i, m0_i});

  always_comb begin
    f_o    = 1'b0;
    cout_o = 1'b0;
    unique case (mode)
      ModeAdd: begin
        f_o    = a_i ^ b_i ^ cin_i;
        cout_o = maj3(a_i, b_i, cin_i);
      end
      ModeSub: begin
        f_o    = a_i ^ ~b_i ^ cin_i;
        cout_o = maj3(a_i, ~b_i, cin_i);
      end
      ModeAnd: begin
        f_o    = a_i & b_i;
        cout_o = cin_i;
      end
      ModeXor: begin
        f_o    = a_i ^ b_i;
        cout_o = cin_i;
      end
      default: begin
        f_o    = 1'b0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: captures operands, streams one bit pair per clock
// LSB first through a single ALU slice, and collects the result word.
module alu_bit_serial_seq
  import alu_bit_serial_seq_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  input  logic             m0_i,
  input  logic             m1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o
);

  localparam logic [CntW-1:0] LastIdx = CntW'(Width - 1);

  state_e           state_q, state_d;
  logic [Width-1:0] a_sh_q, a_sh_d;
  logic [Width-1:0] b_sh_q, b_sh_d;
  logic             m0_q, m0_d;
  logic             m1_q, m1_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic [Width-1:0] res_sh_q, res_sh_d;
  logic [Width-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             slice_f;
  logic             slice_cout;
  logic             accept;
  logic [Width-1:0] res_next;

  alu_bit_serial_seq_alu_1_bit u_slice (
    .a_i    (a_sh_q[idx_q]),
    .b_i    (b_sh_q[idx_q]),
    .cin_i  (carry_q),
    .m0_i   (m0_q),
    .m1_i   (m1_q),
    .f_o    (slice_f),
    .cout_o (slice_cout)
  );

  // start is only honoured when no op is in flight.
  assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    res_next        = res_sh_q;
    res_next[idx_q] = slice_f;
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    m0_d     = m0_q;
    m1_d     = m1_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;

    if (accept) begin
      a_sh_d  = a_i;
      b_sh_d  = b_i;
      m0_d    = m0_i;
      m1_d    = m1_i;
      carry_d = cin_i;
      idx_d   = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StShift;
      end
      StShift: begin
        res_sh_d = res_next;
        carry_d  = slice_cout;
        idx_d    = idx_q + CntW'(1);
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          result_d = res_next;
          cout_d   = slice_cout;
          zero_d   = ~|res_next;
        end
      end
      StDone: begin
        state_d = start_i ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      m0_q     <= 1'b0;
      m1_q     <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      m0_q     <= m0_d;
      m1_q     <= m1_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o   = (state_q == StShift);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed self-checking bench for the bit-serial ALU sequencer (Width = 4).
module tb_alu_bit_serial_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       m0;
  logic       m1;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       cout;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Mode vectors: sub, and, xor, xor-to-zero.
  logic [3:0] mv_a   [4] = '{4'h5, 4'hC, 4'hC, 4'h9};
  logic [3:0] mv_b   [4] = '{4'h3, 4'hA, 4'hA, 4'h9};
  logic       mv_c   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] mv_m   [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
  logic [3:0] mv_res [4] = '{4'h2, 4'h8, 4'h6, 4'h0};
  logic       mv_co  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       mv_z   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  alu_bit_serial_seq #(
    .Width (4),
    .CntW  (2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .cin_i    (cin),
    .m0_i     (m0),
    .m1_i     (m1),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .zero_o   (zero)
  );

  always #5 clk = ~clk;

  // Present an op for one edge, then scramble the inputs to prove they are not used.
  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                       input logic [1:0] tm);
    @(posedge clk);
    #1;
    start = 1'b1; a = ta; b = tb_v; cin = tc; {m1, m0} = tm;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc; {m1, m0} = ~tm;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    #2;
    n_checks++;
    if ({busy, done, result, cout, zero} !== 8'h00) begin
      $display("FAIL reset_outputs: got %b expected 00000000", {busy, done, result, cout, zero});
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL reset_idle: got %0d active cycles expected 0", seen);
      n_fail++;
    end
  endtask

  task automatic test_add_basic();
    int cyc, bc;
    issue(4'h5, 4'h3, 1'b0, 2'b00);
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 5 || bc !== 4) begin
      $display("FAIL add_basic_timing: got done@%0d busy=%0d expected done@5 busy=4", cyc, bc);
      n_fail++;
    end
    n_checks++;
    if ({result, cout, zero} !== {4'h8, 1'b0, 1'b0}) begin
      $display("FAIL add_basic_result: got %h c%b z%b expected 8 c0 z0", result, cout, zero);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 4'h8) begin
      $display("FAIL add_basic_after: got done=%b busy=%b res=%h expected 0 0 8",
               done, busy, result);
      n_fail++;
    end
  endtask

  task automatic test_add_carry_zero();
    int cyc, bc;
    issue(4'hF, 4'h0, 1'b1, 2'b00);
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 5) begin
      $display("FAIL carry_zero_timing: got done@%0d expected done@5", cyc);
      n_fail++;
    end
    n_checks++;
    if ({result, cout, zero} !== {4'h0, 1'b1, 1'b1}) begin
      $display("FAIL carry_zero_result: got %h c%b z%b expected 0 c1 z1", result, cout, zero);
      n_fail++;
    end
  endtask

  task automatic test_modes();
    int cyc, bc;
    for (int i = 0; i < 4; i++) begin
      issue(mv_a[i], mv_b[i], mv_c[i], mv_m[i]);
      wait_done(cyc, bc);
      n_checks++;
      if (cyc !== 5 || {result, cout, zero} !== {mv_res[i], mv_co[i], mv_z[i]}) begin
        $display("FAIL mode_%0d: got done@%0d %h c%b z%b expected done@5 %h c%b z%b",
                 i, cyc, result, cout, zero, mv_res[i], mv_co[i], mv_z[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc, bc;
    issue(4'h5, 4'h3, 1'b0, 2'b00);
    @(negedge clk);
    start = 1'b1; a = 4'h1; b = 4'h0; cin = 1'b0; {m1, m0} = 2'b00;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 3 || bc !== 2) begin
      $display("FAIL start_ignored_timing: got done@%0d busy=%0d expected done@3 busy=2",
               cyc, bc);
      n_fail++;
    end
    n_checks++;
    if ({result, cout, zero} !== {4'h8, 1'b0, 1'b0}) begin
      $display("FAIL start_ignored_result: got %h c%b z%b expected 8 c0 z0", result, cout, zero);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL start_ignored_idle: got busy=%b done=%b expected 0 0", busy, done);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    issue(4'h2, 4'h1, 1'b0, 2'b00);
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 5 || result !== 4'h3) begin
      $display("FAIL b2b_first: got done@%0d res=%h expected done@5 res=3", cyc, result);
      n_fail++;
    end
    start = 1'b1; a = 4'h7; b = 4'h7; cin = 1'b1; {m1, m0} = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 5 || bc !== 4) begin
      $display("FAIL b2b_timing: got done@%0d busy=%0d expected done@5 busy=4", cyc, bc);
      n_fail++;
    end
    n_checks++;
    if ({result, cout, zero} !== {4'hF, 1'b0, 1'b0}) begin
      $display("FAIL b2b_result: got %h c%b z%b expected f c0 z0", result, cout, zero);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, seen;
    issue(4'hF, 4'hF, 1'b1, 2'b00);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, result, cout, zero} !== 8'h00) begin
      $display("FAIL midop_reset_outputs: got %b expected 00000000",
               {busy, done, result, cout, zero});
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL midop_no_done: got %0d active cycles expected 0", seen);
      n_fail++;
    end
    issue(4'h2, 4'h2, 1'b0, 2'b00);
    wait_done(cyc, bc);
    n_checks++;
    if (cyc !== 5 || {result, cout, zero} !== {4'h4, 1'b0, 1'b0}) begin
      $display("FAIL midop_fresh: got done@%0d %h c%b z%b expected done@5 4 c0 z0",
               cyc, result, cout, zero);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    cin = 1'b0;
    m0 = 1'b0;
    m1 = 1'b0;
    test_reset();
    test_add_basic();
    test_add_carry_zero();
    test_modes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
